sqm_bus_writer: RTL and testbench

SQM_BUS_WRITER -- requirements
Module: sqm_bus_writer

---
 rtl/sqm_bus_writer.sv | 196 +++++++++++++++++++
 tb/tb_sqm_bus_writer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sqm_bus_writer.sv
// Queued register writer for a 2-byte-mapped sound chip: FIFO of {adr,data} requests,
// each issued as an address strobe then a data strobe. Optional macro: SQM_ADR_CACHE_EN.
module sqm_bus_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int STROBE_CYC = 2,
    parameter int RECOV_CYC  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [3:0]                    req_adr,
    input  logic [7:0]                    req_data,
    output logic                          bus_adr,
    output logic [7:0]                    bus_din,
    output logic                          bus_cs_n,
    output logic                          bus_wr_n,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = 8;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] STB_LD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] RCV_LD  = CNT_W'((RECOV_CYC > 0) ? RECOV_CYC - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        ADR_SET,
        ADR_WR,
        DAT_SET,
        DAT_WR,
        RECOVER
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [11:0]        mem_q [FIFO_DEPTH];
    logic [7:0]         data_q;
    logic               bus_adr_q, bus_adr_d;
    logic [7:0]         bus_din_q, bus_din_d;
    logic               cs_n_q, cs_n_d;
    logic               wr_n_q, wr_n_d;
    logic               push, pop, hit;
    logic [11:0]        head;

    assign req_ready = (level_q < DEPTH_L);
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == IDLE) && (level_q != '0);
    assign head      = mem_q[rd_ptr_q];

`ifdef SQM_ADR_CACHE_EN
    logic [3:0] last_adr_q, last_adr_d;
    logic       adr_vld_q, adr_vld_d;

    assign hit = adr_vld_q && (last_adr_q == head[11:8]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_adr_q <= 4'h0;
            adr_vld_q  <= 1'b0;
        end else begin
            last_adr_q <= last_adr_d;
            adr_vld_q  <= adr_vld_d;
        end
    end

    // A completed address strobe leaves the chip's address latch holding din[3:0].
    always_comb begin
        last_adr_d = last_adr_q;
        adr_vld_d  = adr_vld_q;
        if (state_q == ADR_WR && cnt_q == '0) begin
            last_adr_d = bus_din_q[3:0];
            adr_vld_d  = 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_adr, req_data};
        if (pop)  data_q <= head[7:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_adr_d = bus_adr_q;
        bus_din_d = bus_din_q;
        cs_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    if (hit) begin
                        state_d   = DAT_SET;
                        bus_adr_d = 1'b1;
                        bus_din_d = head[7:0];
                    end else begin
                        state_d   = ADR_SET;
                        bus_adr_d = 1'b0;
                        bus_din_d = {4'h0, head[11:8]};
                    end
                end
            end
            ADR_SET: begin
                state_d = ADR_WR;
                cnt_d   = STB_LD;
                cs_n_d  = 1'b0;
                wr_n_d  = 1'b0;
            end
            ADR_WR: begin
                if (cnt_q == '0) begin
                    state_d   = DAT_SET;
                    bus_adr_d = 1'b1;
                    bus_din_d = data_q;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    cs_n_d = 1'b0;
                    wr_n_d = 1'b0;
                end
            end
            DAT_SET: begin
                state_d = DAT_WR;
                cnt_d   = STB_LD;
                cs_n_d  = 1'b0;
                wr_n_d  = 1'b0;
            end
            DAT_WR: begin
                if (cnt_q == '0) begin
                    if (RECOV_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RECOVER;
                        cnt_d   = RCV_LD;
                    end
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    cs_n_d = 1'b0;
                    wr_n_d = 1'b0;
                end
            end
            RECOVER: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            bus_adr_q <= 1'b0;
            bus_din_q <= 8'h00;
            cs_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            bus_adr_q <= bus_adr_d;
            bus_din_q <= bus_din_d;
            cs_n_q    <= cs_n_d;
            wr_n_q    <= wr_n_d;
        end
    end

    assign bus_adr  = bus_adr_q;
    assign bus_din  = bus_din_q;
    assign bus_cs_n = cs_n_q;
    assign bus_wr_n = wr_n_q;
    assign busy     = (level_q != '0) || (state_q != IDLE);
    assign level    = level_q;

endmodule

// File: tb/tb_sqm_bus_writer.sv
// Directed bench for sqm_bus_writer: default instance plus a STROBE_CYC=1/RECOV_CYC=0 instance.
module tb_sqm_bus_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req_valid, req_ready, bus_adr, bus_cs_n, bus_wr_n, busy;
    logic [3:0] req_adr;
    logic [7:0] req_data, bus_din;
    logic [2:0] level;

    logic       req_valid_1, req_ready_1, bus_adr_1, bus_cs_n_1, bus_wr_n_1, busy_1;
    logic [3:0] req_adr_1;
    logic [7:0] req_data_1, bus_din_1;
    logic [2:0] level_1;

    sqm_bus_writer u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_adr(req_adr), .req_data(req_data), .bus_adr(bus_adr), .bus_din(bus_din),
        .bus_cs_n(bus_cs_n), .bus_wr_n(bus_wr_n), .busy(busy), .level(level)
    );

    sqm_bus_writer #(.FIFO_DEPTH(4), .STROBE_CYC(1), .RECOV_CYC(0)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid_1), .req_ready(req_ready_1),
        .req_adr(req_adr_1), .req_data(req_data_1), .bus_adr(bus_adr_1), .bus_din(bus_din_1),
        .bus_cs_n(bus_cs_n_1), .bus_wr_n(bus_wr_n_1), .busy(busy_1), .level(level_1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Record {bus_adr, bus_din} at the start of every chip-select pulse.
    logic [8:0] stb_q[$];
    logic       prev_cs = 1'b1;
    always @(negedge clk) begin
        if (prev_cs && !bus_cs_n) stb_q.push_back({bus_adr, bus_din});
        prev_cs <= bus_cs_n;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk_val("idle_wait", 32'(busy), 32'd0);
    endtask

    // Per-cycle expectations after each edge following the push edge (defaults).
    int e2_cs  [11] = '{1, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1};
    int e2_adr [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int e2_din [11] = '{'h07, 'h07, 'h07, 'h38, 'h38, 'h38, 'h38, 'h38, 'h38, 'h38, 'h38};
    int e2_busy[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    // STROBE_CYC=1, RECOV_CYC=0, two back-to-back writes.
    int e6_cs  [10] = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 1};
    int e6_adr [10] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
    int e6_din [10] = '{'h00, 'h00, 'h55, 'h55, 'h55, 'h01, 'h01, 'h02, 'h02, 'h02};
    int e6_busy[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        int base;
        int idx;
        logic rdy;
        reset = 1'b1;
        req_valid = 1'b0; req_adr = 4'h0; req_data = 8'h00;
        req_valid_1 = 1'b0; req_adr_1 = 4'h0; req_data_1 = 8'h00;
        tick();
        chk_val("rst_cs_n",  32'(bus_cs_n),  32'd1);
        chk_val("rst_wr_n",  32'(bus_wr_n),  32'd1);
        chk_val("rst_adr",   32'(bus_adr),   32'd0);
        chk_val("rst_din",   32'(bus_din),   32'd0);
        chk_val("rst_level", 32'(level),     32'd0);
        chk_val("rst_busy",  32'(busy),      32'd0);
        chk_val("rst_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Single write (7, 0x38) with default timing.
        req_valid = 1'b1; req_adr = 4'd7; req_data = 8'h38;
        tick();
        req_valid = 1'b0;
        chk_val("w1_level", 32'(level), 32'd1);
        chk_val("w1_busy",  32'(busy),  32'd1);
        for (int k = 0; k < 11; k++) begin
            tick();
            chk_val($sformatf("w1_cs_%0d", k + 1),   32'(bus_cs_n), 32'(e2_cs[k]));
            chk_val($sformatf("w1_wr_%0d", k + 1),   32'(bus_wr_n), 32'(e2_cs[k]));
            chk_val($sformatf("w1_adr_%0d", k + 1),  32'(bus_adr),  32'(e2_adr[k]));
            chk_val($sformatf("w1_din_%0d", k + 1),  32'(bus_din),  32'(e2_din[k]));
            chk_val($sformatf("w1_busy_%0d", k + 1), 32'(busy),     32'(e2_busy[k]));
        end

        // Hold req_valid 6 cycles into a depth-4 FIFO.
        base = stb_q.size();
        idx = 0;
        req_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req_adr  = idx[3:0];
            req_data = 8'(8'hA0 + idx);
            rdy = req_ready;
            tick();
            if (rdy) idx++;
            if (c == 1) chk_val("burst_pop_level", 32'(level), 32'd1);
            if (c >= 4) begin
                chk_val($sformatf("burst_ready_%0d", c), 32'(req_ready), 32'd0);
                chk_val($sformatf("burst_level_%0d", c), 32'(level),     32'd4);
            end
        end
        req_valid = 1'b0;
        chk_val("burst_accepted", 32'(idx), 32'd5);
        wait_idle(300);
        chk_val("burst_strobes", 32'(stb_q.size() - base), 32'd10);
        for (int i = 0; i < 5; i++) begin
            if (stb_q.size() >= base + 2 * i + 2) begin
                chk_val($sformatf("burst_adr_%0d", i), 32'(stb_q[base + 2 * i]),     32'(9'h000 + i));
                chk_val($sformatf("burst_dat_%0d", i), 32'(stb_q[base + 2 * i + 1]), 32'(9'h1A0 + i));
            end
        end

        // Same address twice: cache build skips the second address phase.
        base = stb_q.size();
        req_valid = 1'b1; req_adr = 4'd8; req_data = 8'h10;
        tick();
        req_data = 8'h1F;
        tick();
        req_valid = 1'b0;
        wait_idle(100);
`ifdef SQM_ADR_CACHE_EN
        chk_val("cache_pulses", 32'(stb_q.size() - base), 32'd3);
`else
        chk_val("cache_pulses", 32'(stb_q.size() - base), 32'd4);
`endif
        if (stb_q.size() > base) chk_val("cache_last", 32'(stb_q[$]), 32'h11F);

        // Reset during the second DAT_WR cycle with one entry still queued.
        req_valid = 1'b1; req_adr = 4'd3; req_data = 8'h44;
        tick();
        req_adr = 4'd5; req_data = 8'h66;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        chk_val("abort_pre_cs", 32'(bus_cs_n), 32'd0);
        reset = 1'b1;
        #1;
        chk_val("abort_cs_n",  32'(bus_cs_n),  32'd1);
        chk_val("abort_wr_n",  32'(bus_wr_n),  32'd1);
        chk_val("abort_level", 32'(level),     32'd0);
        chk_val("abort_busy",  32'(busy),      32'd0);
        chk_val("abort_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        base = stb_q.size();
        req_valid = 1'b1; req_adr = 4'd9; req_data = 8'h12;
        tick();
        req_valid = 1'b0;
        wait_idle(100);
        chk_val("post_rst_pulses", 32'(stb_q.size() - base), 32'd2);
        if (stb_q.size() >= base + 2) begin
            chk_val("post_rst_adr", 32'(stb_q[base]),     32'h009);
            chk_val("post_rst_dat", 32'(stb_q[base + 1]), 32'h112);
        end

        // Fast instance: back-to-back writes, no recovery.
        req_valid_1 = 1'b1; req_adr_1 = 4'd0; req_data_1 = 8'h55;
        tick();
        req_adr_1 = 4'd1; req_data_1 = 8'h02;
        tick();
        req_valid_1 = 1'b0;
        chk_val("fast_level_1", 32'(level_1), 32'd1);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            chk_val($sformatf("fast_cs_%0d", k + 1),   32'(bus_cs_n_1), 32'(e6_cs[k]));
            chk_val($sformatf("fast_wr_%0d", k + 1),   32'(bus_wr_n_1), 32'(e6_cs[k]));
            chk_val($sformatf("fast_adr_%0d", k + 1),  32'(bus_adr_1),  32'(e6_adr[k]));
            chk_val($sformatf("fast_din_%0d", k + 1),  32'(bus_din_1),  32'(e6_din[k]));
            chk_val($sformatf("fast_busy_%0d", k + 1), 32'(busy_1),     32'(e6_busy[k]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
